// File: rtl/membus_arbiter_if.sv
// membus_arbiter_if
//   Bundles the fetch requester (i_*), the load/store requester (d_*) and the
//   single memory port (m_*) that the arbiter connects between them.
//   Modports:
//     slave  - the arbiter's view: it takes requests from both requesters
//              and memory responses, and drives readies, responses and the
//              memory request.
//     master - the surrounding system's view: the requesters and the memory.
//   Signals per requester (x = i or d):
//     x_valid/x_ready        request handshake
//     x_addr  [XLEN]         byte address
//     x_wen, x_wdata         write enable and write data
//     x_rvalid, x_rdata      routed response
//   Memory side:
//     m_valid/m_ready        request handshake
//     m_addr  [ADDR_WIDTH]   word address
//     m_wen, m_wdata         write enable and write data
//     m_rvalid, m_rdata      one response per accepted request
interface membus_arbiter_if #(
  parameter int XLEN       = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
);
  logic                  i_valid;
  logic                  i_ready;
  logic [XLEN-1:0]       i_addr;
  logic                  i_wen;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_valid;
  logic                  d_ready;
  logic [XLEN-1:0]       d_addr;
  logic                  d_wen;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_wen;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport slave (
    input  i_valid, i_addr, i_wen, i_wdata,
    output i_ready, i_rvalid, i_rdata,
    input  d_valid, d_addr, d_wen, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output m_valid, m_addr, m_wen, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport master (
    output i_valid, i_addr, i_wen, i_wdata,
    input  i_ready, i_rvalid, i_rdata,
    output d_valid, d_addr, d_wen, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_valid, m_addr, m_wen, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one memory port between the instruction-fetch requester and the
//   load/store requester. One request is outstanding at a time; the grant is
//   held until memory answers, and the answer is routed back to the owner.
//   Data requests win ties, but after MAX_D_STREAK consecutive data grants
//   with fetch waiting, fetch is granted once.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous reset, active-low; forces every output to 0
//     bus  - membus_arbiter_if.slave (both requesters plus the memory port)
module membus_arbiter #(
  parameter int XLEN         = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  membus_arbiter_if.slave   bus
);
  // Byte offset of a word: memory is word addressed.
  localparam int BOFF = $clog2(DATA_WIDTH / 8);
  localparam int AHI  = ADDR_WIDTH + BOFF - 1;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {ST_IDLE, ST_WAIT_RESP} state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_holdValid;
  logic       r_holdOwner;
  logic [3:0] r_streak;

  logic w_selAny;
  logic w_selD;
  logic w_idle;
  logic w_mValid;
  logic w_xfer;
  logic w_wait;
  logic w_respI;
  logic w_respD;

  // A stalled offer keeps its requester until it transfers; otherwise data
  // wins unless fetch is waiting and the data streak is exhausted.
  always_comb begin
    w_selAny = 1'b0;
    w_selD   = 1'b0;
    if (r_holdValid) begin
      w_selAny = 1'b1;
      w_selD   = r_holdOwner;
    end else if (bus.d_valid && !(bus.i_valid && (r_streak == STREAK_MAX))) begin
      w_selAny = 1'b1;
      w_selD   = 1'b1;
    end else if (bus.i_valid) begin
      w_selAny = 1'b1;
    end
  end

  // Gating with rst keeps every output at 0 while reset is held, even
  // before the first clock edge has cleared the state.
  assign w_idle   = rst && (r_state == ST_IDLE);
  assign w_wait   = rst && (r_state == ST_WAIT_RESP);
  assign w_mValid = w_idle && w_selAny && (w_selD ? bus.d_valid : bus.i_valid);
  assign w_xfer   = w_mValid && bus.m_ready;

  assign bus.m_valid = w_mValid;
  assign bus.m_addr  = (w_idle && w_selAny)
                     ? (w_selD ? bus.d_addr[AHI:BOFF] : bus.i_addr[AHI:BOFF])
                     : '0;
  assign bus.m_wen   = w_idle && w_selAny && (w_selD ? bus.d_wen : bus.i_wen);
  assign bus.m_wdata = (w_idle && w_selAny)
                     ? (w_selD ? bus.d_wdata : bus.i_wdata)
                     : '0;

  assign bus.i_ready = w_idle && w_selAny && !w_selD && bus.m_ready;
  assign bus.d_ready = w_idle && w_selD && bus.m_ready;

  // Responses are only meaningful while a request is outstanding; a stray
  // m_rvalid in IDLE is dropped.
  assign w_respI      = w_wait && (r_owner == OWN_I) && bus.m_rvalid;
  assign w_respD      = w_wait && (r_owner == OWN_D) && bus.m_rvalid;
  assign bus.i_rvalid = w_respI;
  assign bus.i_rdata  = w_respI ? bus.m_rdata : '0;
  assign bus.d_rvalid = w_respD;
  assign bus.d_rdata  = w_respD ? bus.m_rdata : '0;

  // Grant FSM: IDLE forwards one request, WAIT_RESP waits for its answer.
  // The streak counts data grants taken while fetch was asking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_I;
      r_holdValid <= 1'b0;
      r_holdOwner <= OWN_I;
      r_streak    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state     <= ST_WAIT_RESP;
            r_owner     <= w_selD;
            r_holdValid <= 1'b0;
            if (w_selD && bus.i_valid) begin
              if (r_streak < STREAK_MAX) r_streak <= r_streak + 4'd1;
            end else begin
              r_streak <= '0;
            end
          end else if (w_mValid) begin
            r_holdValid <= 1'b1;
            r_holdOwner <= w_selD;
          end
        end
        ST_WAIT_RESP: begin
          if (bus.m_rvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter
//   Drives both requesters and a small memory, and compares every cycle's
//   outputs with a transaction-level reference model of the arbitration
//   rules. Directed scenarios come first, then randomized traffic.
module tb_membus_arbiter;
  localparam int XLEN = 64;
  localparam int DW   = 32;
  localparam int AW   = 20;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  membus_arbiter_if #(.XLEN(XLEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  membus_arbiter #(
    .XLEN(XLEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a request is in flight, who owns it, which
  // requester's stalled offer must be honoured, and how many data grants
  // were taken in a row while fetch was asking.
  bit mBusy, mOwnerD, mHeld, mHeldD;
  int mStreak;

  // Memory and requester bookkeeping for the random phase.
  bit memOut;
  int memWait;
  bit iAcc, dAcc;

  logic [15:0] grantHist;
  int grantCount;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Called mid-cycle: predicts every output from the current inputs, checks
  // them, then moves the model to the state after the coming edge.
  task automatic evalCycle();
    bit gV, gD;
    logic [63:0] sAddr;
    logic [5:0]  eCtrl, oCtrl;
    logic [19:0] eAddr;
    logic [31:0] eWdata, eIr, eDr;
    #3;
    gV = 0; gD = 0; eCtrl = '0; eAddr = '0; eWdata = '0; eIr = '0; eDr = '0; sAddr = '0;
    if (rst) begin
      if (!mBusy) begin
        if (mHeld) begin
          gV = 1; gD = mHeldD;
        end else if (bus.d_valid && !(bus.i_valid && mStreak >= MAXS)) begin
          gV = 1; gD = 1;
        end else if (bus.i_valid) begin
          gV = 1; gD = 0;
        end
        if (gV) begin
          sAddr  = gD ? bus.d_addr : bus.i_addr;
          sAddr  = sAddr >> 2;
          eAddr  = sAddr[19:0];
          eWdata = gD ? bus.d_wdata : bus.i_wdata;
          eCtrl  = {1'b1, !gD && bus.m_ready, gD && bus.m_ready, 1'b0, 1'b0,
                    gD ? bus.d_wen : bus.i_wen};
        end
      end else if (bus.m_rvalid) begin
        if (mOwnerD) begin eCtrl[1] = 1'b1; eDr = bus.m_rdata; end
        else         begin eCtrl[2] = 1'b1; eIr = bus.m_rdata; end
      end
    end
    oCtrl = {bus.m_valid, bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid, bus.m_wen};
    checkOutput("ctrl",    64'(oCtrl),       64'(eCtrl));
    checkOutput("m_addr",  64'(bus.m_addr),  64'(eAddr));
    checkOutput("m_wdata", 64'(bus.m_wdata), 64'(eWdata));
    checkOutput("i_rdata", 64'(bus.i_rdata), 64'(eIr));
    checkOutput("d_rdata", 64'(bus.d_rdata), 64'(eDr));

    if (!rst) begin
      mBusy = 0; mOwnerD = 0; mHeld = 0; mHeldD = 0; mStreak = 0; memOut = 0;
    end else if (!mBusy) begin
      if (gV && bus.m_ready) begin
        mBusy   = 1;
        mOwnerD = gD;
        mHeld   = 0;
        if (gD && bus.i_valid) mStreak = (mStreak + 1 > MAXS) ? MAXS : mStreak + 1;
        else                   mStreak = 0;
        grantHist = {grantHist[14:0], gD};
        grantCount++;
        if (gD) dAcc = 1; else iAcc = 1;
        memOut  = 1;
        memWait = $urandom_range(0, 2);
      end else if (gV) begin
        mHeld = 1; mHeldD = gD;
      end
    end else if (bus.m_rvalid) begin
      mBusy  = 0;
      memOut = 0;
    end
  endtask

  task automatic clearInputs();
    bus.i_valid = 0; bus.i_addr = '0; bus.i_wen = 0; bus.i_wdata = '0;
    bus.d_valid = 0; bus.d_addr = '0; bus.d_wen = 0; bus.d_wdata = '0;
    bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
  endtask

  // Random traffic: requesters hold their offers until accepted, memory
  // answers 1..3 cycles after a transfer and sometimes sends a stray
  // response while idle; reset occasionally strikes.
  task automatic applyStimulus();
    if (iAcc) bus.i_valid = 0;
    if (dAcc) bus.d_valid = 0;
    iAcc = 0; dAcc = 0;
    if (!bus.i_valid && $urandom_range(0, 1) == 1) begin
      bus.i_valid = 1;
      bus.i_addr  = {$urandom, $urandom};
      bus.i_wdata = $urandom;
      bus.i_wen   = 0;
    end
    if (!bus.d_valid && $urandom_range(0, 1) == 1) begin
      bus.d_valid = 1;
      bus.d_addr  = {$urandom, $urandom};
      bus.d_wdata = $urandom;
      bus.d_wen   = 1'($urandom_range(0, 1));
    end
    bus.m_ready = ($urandom_range(0, 3) != 0);
    bus.m_rdata = $urandom;
    if (memOut) begin
      if (memWait == 0) bus.m_rvalid = 1;
      else begin bus.m_rvalid = 0; memWait--; end
    end else begin
      bus.m_rvalid = ($urandom_range(0, 15) == 0);
    end
    rst = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    mBusy = 0; mOwnerD = 0; mHeld = 0; mHeldD = 0; mStreak = 0;
    memOut = 0; memWait = 0; iAcc = 0; dAcc = 0; grantHist = '0; grantCount = 0;

    // Reset with both requesters shouting: outputs must stay quiet.
    rst = 0;
    clearInputs();
    bus.i_valid = 1; bus.d_valid = 1; bus.m_ready = 1; bus.m_rvalid = 1;
    advance();
    evalCycle();
    checkOutput("rstMValid", 64'(bus.m_valid), 64'd0);
    checkOutput("rstIReady", 64'(bus.i_ready), 64'd0);
    checkOutput("rstDReady", 64'(bus.d_ready), 64'd0);
    advance();
    evalCycle();
    advance();

    // Single fetch with a 1-cycle memory.
    rst = 1;
    clearInputs();
    bus.i_valid = 1; bus.i_addr = 64'h0000_1004; bus.m_ready = 1;
    evalCycle();
    checkOutput("fetchAddr",  64'(bus.m_addr),  64'h00401);
    checkOutput("fetchReady", 64'(bus.i_ready), 64'd1);
    advance();
    bus.i_valid = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
    evalCycle();
    checkOutput("fetchRvalid", 64'(bus.i_rvalid), 64'd1);
    checkOutput("fetchRdata",  64'(bus.i_rdata),  64'hDEADBEEF);
    checkOutput("fetchDRvalid", 64'(bus.d_rvalid), 64'd0);
    advance();

    // Simultaneous requests: data first, fetch right after its response.
    bus.m_rvalid = 0;
    bus.i_valid = 1; bus.i_addr = 64'h2000;
    bus.d_valid = 1; bus.d_addr = 64'h3000;
    evalCycle();
    checkOutput("tieDReady", 64'(bus.d_ready), 64'd1);
    checkOutput("tieIReady", 64'(bus.i_ready), 64'd0);
    advance();
    bus.d_valid = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h1111_2222;
    evalCycle();
    checkOutput("tieDRvalid", 64'(bus.d_rvalid), 64'd1);
    checkOutput("tieNoFwdInResp", 64'(bus.m_valid), 64'd0);
    advance();
    bus.m_rvalid = 0;
    evalCycle();
    checkOutput("tieIThen", 64'(bus.i_ready), 64'd1);
    advance();
    bus.i_valid = 0; bus.m_rvalid = 1;
    evalCycle();
    advance();
    bus.m_rvalid = 0;

    // Starvation bound: both always asking, 10 grants.
    grantHist = '0; grantCount = 0;
    bus.i_valid = 1; bus.d_valid = 1;
    for (int k = 0; k < 10; k++) begin
      bus.d_addr = 64'(k * 4);
      evalCycle();
      advance();
      bus.m_rvalid = 1;
      evalCycle();
      advance();
      bus.m_rvalid = 0;
    end
    checkOutput("grantOrder", 64'(grantHist[9:0]), 64'(10'b1111011110));
    bus.i_valid = 0; bus.d_valid = 0;

    // Hold under backpressure: the stalled fetch offer keeps the grant.
    bus.m_ready = 0;
    bus.i_valid = 1; bus.i_addr = 64'h0000_0040;
    evalCycle();
    checkOutput("holdAddr0", 64'(bus.m_addr), 64'h10);
    advance();
    bus.d_valid = 1; bus.d_addr = 64'h0000_0080;
    evalCycle();
    checkOutput("holdAddr1", 64'(bus.m_addr),  64'h10);
    checkOutput("holdDReady", 64'(bus.d_ready), 64'd0);
    advance();
    evalCycle();
    checkOutput("holdAddr2", 64'(bus.m_addr), 64'h10);
    advance();
    bus.m_ready = 1;
    evalCycle();
    checkOutput("holdIGo", 64'(bus.i_ready), 64'd1);
    advance();
    bus.i_valid = 0; bus.m_rvalid = 1;
    evalCycle();
    advance();
    bus.m_rvalid = 0;
    evalCycle();
    checkOutput("holdDGo",   64'(bus.d_ready), 64'd1);
    checkOutput("holdDAddr", 64'(bus.m_addr),  64'h20);
    advance();
    bus.d_valid = 0; bus.m_rvalid = 1;
    evalCycle();
    advance();
    bus.m_rvalid = 0;

    // Write through the data port, answered three cycles later.
    bus.d_valid = 1; bus.d_wen = 1; bus.d_addr = 64'h8; bus.d_wdata = 32'h12345678;
    evalCycle();
    checkOutput("wrWen",   64'(bus.m_wen),   64'd1);
    checkOutput("wrAddr",  64'(bus.m_addr),  64'h2);
    checkOutput("wrWdata", 64'(bus.m_wdata), 64'h12345678);
    advance();
    bus.d_valid = 0; bus.d_wen = 0;
    for (int k = 0; k < 2; k++) begin
      evalCycle();
      checkOutput("wrGap", 64'(bus.m_valid), 64'd0);
      advance();
    end
    bus.m_rvalid = 1;
    evalCycle();
    checkOutput("wrResp", 64'(bus.d_rvalid), 64'd1);
    advance();
    bus.m_rvalid = 0;

    // Reset while a fetch is outstanding, then a stray response.
    bus.i_valid = 1; bus.i_addr = 64'h100;
    evalCycle();
    advance();
    bus.i_valid = 0; rst = 0;
    evalCycle();
    advance();
    rst = 1;
    evalCycle();
    checkOutput("rstAfterMValid", 64'(bus.m_valid), 64'd0);
    advance();
    bus.i_valid = 1; bus.i_addr = 64'h200; bus.m_rvalid = 1; bus.m_rdata = 32'hBAD0BAD0;
    evalCycle();
    checkOutput("postRstFwd",   64'(bus.i_ready),  64'd1);
    checkOutput("staleIRvalid", 64'(bus.i_rvalid), 64'd0);
    checkOutput("staleDRvalid", 64'(bus.d_rvalid), 64'd0);
    advance();
    bus.i_valid = 0; bus.m_rdata = 32'h0000_0077;
    evalCycle();
    checkOutput("postRstResp", 64'(bus.i_rdata), 64'h77);
    advance();
    bus.m_rvalid = 0;

    // Randomized traffic.
    iAcc = 0; dAcc = 0; memOut = mBusy;
    memWait = 0;
    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      evalCycle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
